// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - Round-robin arbiter sharing one APB bus between two single-word requesters
module apb_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic                r0_req,
  input  logic                r0_write,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_strb,
  output logic                r0_ack,
  output logic [DATA_W-1:0]   r0_rdata,
  output logic                r0_err,
  input  logic                r1_req,
  input  logic                r1_write,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_strb,
  output logic                r1_ack,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                r1_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t              state;
  logic                last;
  logic [15:0]         wait_cnt;
  logic                req0_live;
  logic                req1_live;
  logic                pick1;
  logic                done;
  logic                done_err;
  logic [DATA_W-1:0]   done_rdata;

  // A requester being acked this cycle must not be re-granted on its stale req.
  always_comb begin
    req0_live  = r0_req & ~r0_ack;
    req1_live  = r1_req & ~r1_ack;
    pick1      = req1_live & (~req0_live | ~last);
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    if (state == ACCESS) begin
      if (pready) begin
        done       = 1'b1;
        done_err   = pslverr;
        done_rdata = pwrite ? '0 : prdata;
      end else if (wait_cnt == TIMEOUT_CNT) begin
        done     = 1'b1;
        done_err = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      wait_cnt <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      r0_ack   <= 1'b0;
      r0_err   <= 1'b0;
      r0_rdata <= '0;
      r1_ack   <= 1'b0;
      r1_err   <= 1'b0;
      r1_rdata <= '0;
    end else begin
      r0_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_ack <= 1'b0;
      r1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_live | req1_live) begin
            grant    <= pick1 ? 2'b10 : 2'b01;
            last     <= pick1;
            pwrite   <= pick1 ? r1_write : r0_write;
            paddr    <= pick1 ? r1_addr : r0_addr;
            pwdata   <= pick1 ? r1_wdata : r0_wdata;
            pstrb    <= pick1 ? (r1_write ? r1_strb : '0) : (r0_write ? r0_strb : '0);
            psel     <= 1'b1;
            penable  <= 1'b0;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            grant   <= 2'b00;
            state   <= IDLE;
            if (grant[1]) begin
              r1_ack   <= 1'b1;
              r1_err   <= done_err;
              r1_rdata <= done_rdata;
            end else begin
              r0_ack   <= 1'b1;
              r0_err   <= done_err;
              r0_rdata <= done_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
